// File: rtl/io_terminal_pkg.sv
// Shared types for the programmed-I/O terminal adapter: FSM state encodings
// and the default character width.
package io_terminal_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_WSET = 2'd1,
    I_WCLR = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    O_SIGNAL = 2'd0,
    O_WSET   = 2'd1,
    O_WOUT   = 2'd2,
    O_SEND   = 2'd3
  } out_state_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO for the terminal input path. Push is ignored when
// full, pop is ignored when empty; simultaneous push/pop keeps count steady.
// Pointers wrap modulo DEPTH (DEPTH must be a power of two, >= 2).
module io_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == {(PTR_W + 1){1'b0}});
  assign head  = mem_q[rd_ptr_q];

  // Qualify requests and compute next pointer/count values.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards stored contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/io_terminal_adapter.sv
// Device-side terminal for the basic computer's INPR/FGI and OUTR/FGO
// programmed-I/O interface. Host bytes are buffered in io_fifo and handed to
// the CPU one at a time through INPR/FGI; bytes the CPU writes with OUT are
// captured from OUTR and streamed to the host.
// Optional build macro IO_TERMINAL_LOOPBACK_EN adds a 'loopback' input that
// routes OUT bytes back into the input FIFO instead of the host stream.
module io_terminal_adapter
  import io_terminal_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] INPR_in,
  output logic              set_FGI,
  input  logic              FGI_out,
  input  logic [DATA_W-1:0] OUTR_out,
  output logic              set_FGO,
  input  logic              FGO_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef IO_TERMINAL_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              out_ready
);

  in_state_t         in_state_q, in_state_d;
  out_state_t        out_state_q, out_state_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic              set_fgi_q, set_fgi_d;
  logic              set_fgo_q, set_fgo_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_pop_s;
  logic              fifo_push_s;
  logic [DATA_W-1:0] fifo_push_data_s;
  logic              lb_push_s;

  assign INPR_in   = inpr_q;
  assign set_FGI   = set_fgi_q;
  assign set_FGO   = set_fgo_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // A loopback push owns the FIFO write port for its cycle, so the host is
  // held off then as well as when the FIFO is full.
  assign in_ready = !fifo_full_s && !lb_push_s;

  // Select the FIFO write source: loopback byte has priority over the host.
  always_comb begin
    fifo_push_s      = 1'b0;
    fifo_push_data_s = in_data;
    if (lb_push_s) begin
      fifo_push_s      = 1'b1;
      fifo_push_data_s = OUTR_out;
    end else begin
      fifo_push_s      = in_valid && in_ready;
      fifo_push_data_s = in_data;
    end
  end

  io_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push_s),
    .push_data (fifo_push_data_s),
    .pop       (fifo_pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  // Input FSM: offer one byte, pulse set_FGI, then wait for the CPU's
  // FGI set/clear round trip before offering the next. INPR stays put
  // until the FSM is back in idle.
  always_comb begin
    in_state_d = in_state_q;
    inpr_d     = inpr_q;
    set_fgi_d  = 1'b0;
    fifo_pop_s = 1'b0;
    case (in_state_q)
      I_IDLE: begin
        if (!fifo_empty_s && !FGI_out) begin
          inpr_d     = fifo_head_s;
          set_fgi_d  = 1'b1;
          fifo_pop_s = 1'b1;
          in_state_d = I_WSET;
        end else begin
          in_state_d = I_IDLE;
        end
      end
      I_WSET: begin
        if (FGI_out) begin
          in_state_d = I_WCLR;
        end else begin
          in_state_d = I_WSET;
        end
      end
      I_WCLR: begin
        if (!FGI_out) begin
          in_state_d = I_IDLE;
        end else begin
          in_state_d = I_WCLR;
        end
      end
      default: begin
        in_state_d = I_IDLE;
      end
    endcase
  end

  // Output FSM: announce readiness with set_FGO, wait for the CPU to see it
  // and then execute OUT (FGO falls with OUTR already loaded), capture the
  // byte and hand it to the host (or to the input FIFO in loopback).
  always_comb begin
    out_state_d = out_state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    set_fgo_d   = 1'b0;
    lb_push_s   = 1'b0;
    case (out_state_q)
      O_SIGNAL: begin
        set_fgo_d   = 1'b1;
        out_valid_d = 1'b0;
        out_state_d = O_WSET;
      end
      O_WSET: begin
        if (FGO_out) begin
          out_state_d = O_WOUT;
        end else begin
          out_state_d = O_WSET;
        end
      end
      O_WOUT: begin
        if (!FGO_out) begin
`ifdef IO_TERMINAL_LOOPBACK_EN
          if (loopback) begin
            // OUTR is held by the CPU until its next OUT, which needs FGO
            // set again, so waiting here on a full FIFO is safe.
            if (!fifo_full_s) begin
              lb_push_s   = 1'b1;
              out_state_d = O_SIGNAL;
            end else begin
              out_state_d = O_WOUT;
            end
          end else begin
            out_data_d  = OUTR_out;
            out_valid_d = 1'b1;
            out_state_d = O_SEND;
          end
`else
          out_data_d  = OUTR_out;
          out_valid_d = 1'b1;
          out_state_d = O_SEND;
`endif
        end else begin
          out_state_d = O_WOUT;
        end
      end
      O_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_state_d = O_SIGNAL;
        end else begin
          out_state_d = O_SEND;
        end
      end
      default: begin
        out_state_d = O_SIGNAL;
      end
    endcase
  end

  // State and registered outputs for both FSMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= I_IDLE;
      out_state_q <= O_SIGNAL;
      inpr_q      <= {DATA_W{1'b0}};
      set_fgi_q   <= 1'b0;
      set_fgo_q   <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      inpr_q      <= inpr_d;
      set_fgi_q   <= set_fgi_d;
      set_fgo_q   <= set_fgo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
